seg_reader: RTL and testbench
=============================

# seg_reader

Reads a time-multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and recovers the hex word it shows. It is the receiving end of the hex-to-7-segment decoder path. Each digit's pattern must hold stable for a programmable number of cycles before it is accepted. Once all digits of a frame are captured, the block presents the word on a valid/ready handshake. It sits between a display-scan source (or a loopback of our own decoder outputs) and downstream checking or processing logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is accepted; legal range 1..255.
- `NDIG`, default 4: number of multiplexed digits; legal range 1..8.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `seg`  in  7: segment lines, active-high; bit0 = a … bit6 = g.
- `dig`  in  NDIG: digit strobes, one-hot; bit i selects nibble i (nibble 0 = bits 3:0).
- `out_data`  out  4*NDIG: assembled hex word.
- `out_err`  out  1: at least one digit in the presented frame had an unrecognised pattern.
- `out_valid`  out  1: `out_data` and `out_err` are valid.
- `out_ready`  in  1: consumer accepts the word.

## Operation
- Pattern map (seg hex → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67 or 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. Every other pattern is invalid.
- Sample register captures {seg, dig} every cycle.
- Stability counter `cnt`, 8 bits, saturating at STABLE_CYCLES:
  - Cleared when the new sample differs from the held sample, or when `dig` is not one-hot (zero or multiple bits set).
  - Otherwise increments.
- Capture fires once per dwell, at the edge where `cnt` reaches STABLE_CYCLES, in state COLLECT only:
  - Writes the decoded nibble into slot i.
  - Sets `done[i]`.
  - Sets `err[i]` if the pattern is invalid; the nibble is then written as 0.
- Re-capture of an already-done slot in the same frame overwrites that slot (latest wins).
- State machine:
  - COLLECT: capture as above. When `done` becomes all-ones → PRESENT.
  - PRESENT: `out_valid`=1; `out_data` and `out_err` held constant; captures suppressed.
  - PRESENT, on `out_valid && out_ready` → COLLECT, with `done` and `err` cleared and `cnt` cleared.
- `out_err` = OR of `err[NDIG-1:0]`, registered.

## Timing
- Reset values:
  - `out_data` = 0, `out_err` = 0, `out_valid` = 0.
  - state COLLECT, `done` = 0, `err` = 0, `cnt` = 0, sample register = 0.
- Capture latency: with {seg, dig} set up before edge 0 and held, the slot is written at edge STABLE_CYCLES.
- `out_valid` rises on the same edge that the final slot is written.
- Handshake:
  - The transfer completes on the edge where `out_valid` and `out_ready` are both high.
  - `out_valid` drops on that edge.
  - `out_ready` while `out_valid`=0 has no effect.
- After a transfer, a dwell already stable does not capture again. `cnt` restarts, so the next capture needs STABLE_CYCLES further cycles.
- A glitch of one cycle restarts the count; no partial capture.
- Reset asserted mid-frame: all state cleared immediately (asynchronous); no word is presented for the partial frame.
- NDIG=1: every capture goes directly to PRESENT.

## Structure
- Shared package `seg_pkg`:
  - 7-bit segment pattern constants SEG_0..SEG_F plus SEG_9_ALT.
  - State enum {COLLECT, PRESENT}.
- Sub-module `seg7_encode`: combinational, `seg[6:0]` → {nibble[3:0], valid}. It is reused by any future display-loopback checker.
- Top `seg_reader` holds the sample register, counter, slot registers and state machine.

## Test plan
- Basic frame: scan 3F/dig=0001, 06/0010, 5B/0100, 4F/1000, each held 6 cycles → `out_valid` with `out_data`=0x3210, `out_err`=0.
- Stability: pattern 7F held 3 cycles with STABLE_CYCLES=4, then changed → no capture. Held 4 cycles → slot written at edge 4.
- Invalid: digit 2 shows 0x01 within an otherwise valid frame (all others 7F) → `out_data`=0x8088, `out_err`=1.
- Backpressure: `out_ready`=0 for 10 cycles while scanning continues with new digits → `out_data` unchanged and `out_valid` held. Assert `out_ready` → valid drops next edge; the next frame captures fresh values.
- Strobe faults: `dig`=0000 and `dig`=0011 held 20 cycles → no capture and `done` unchanged. Alternate patterns 67 and 6F on digit 0 → both decode to 9.
- Reset: assert `resetn`=0 after 3 of 4 digits captured → outputs 0 asynchronously. After release, a full new scan is required before `out_valid`.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment bus reader: segment pattern constants
// (bit0 = a ... bit6 = g) and the frame state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_9_ALT = 7'h67;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational inverse of a hex-to-7-segment decoder: maps a segment
// pattern back to its nibble and flags patterns that are not a hex glyph.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    // Pattern lookup; anything outside the glyph set decodes to 0 and is flagged
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_9_ALT: nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// Recovers the hex word shown on a multiplexed 7-segment bus: each digit must
// dwell unchanged for STABLE_CYCLES before capture; full frames go out on valid/ready.
module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int NDIG          = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     dig,
    output logic [4*NDIG-1:0]   out_data,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    state_t              state_r, state_s;
    logic [6:0]          sample_seg_r;
    logic [NDIG-1:0]     sample_dig_r;
    logic [7:0]          cnt_r, cnt_s;
    logic [NDIG-1:0]     done_r, done_s;
    logic [NDIG-1:0]     err_r, err_s;
    logic [4*NDIG-1:0]   data_r, data_s;
    logic                out_err_r, out_valid_r;

    logic [3:0]          enc_nibble_s;
    logic                enc_valid_s;
    logic                same_s;
    logic                onehot_s;
    logic                capture_s;
    logic                handshake_s;

    seg7_encode u_encode (
        .seg    (seg),
        .nibble (enc_nibble_s),
        .valid  (enc_valid_s)
    );

    // Dwell tracking: the count restarts on any change or an illegal strobe
    always_comb begin
        same_s   = (seg == sample_seg_r) && (dig == sample_dig_r);
        onehot_s = $onehot(dig);
        cnt_s    = cnt_r;
        if (!same_s || !onehot_s) begin
            cnt_s = 8'd0;
        end else if (cnt_r < STABLE_CNT) begin
            cnt_s = cnt_r + 8'd1;
        end else begin
            cnt_s = cnt_r;
        end
        // Fires only on the transition into the saturated value, i.e. once per dwell
        capture_s   = (state_r == COLLECT) && (cnt_r != STABLE_CNT) && (cnt_s == STABLE_CNT);
        handshake_s = (state_r == PRESENT) && out_ready;
    end

    // Slot updates and frame state sequencing
    always_comb begin
        state_s = state_r;
        done_s  = done_r;
        err_s   = err_r;
        data_s  = data_r;
        if (handshake_s) begin
            done_s = {NDIG{1'b0}};
            err_s  = {NDIG{1'b0}};
        end else if (capture_s) begin
            for (int i = 0; i < NDIG; i++) begin
                if (dig[i]) begin
                    data_s[4*i +: 4] = enc_valid_s ? enc_nibble_s : 4'h0;
                    done_s[i]        = 1'b1;
                    err_s[i]         = ~enc_valid_s;
                end else begin
                    data_s[4*i +: 4] = data_r[4*i +: 4];
                end
            end
        end else begin
            data_s = data_r;
        end

        case (state_r)
            COLLECT: begin
                if (&done_s) begin
                    state_s = PRESENT;
                end else begin
                    state_s = COLLECT;
                end
            end
            PRESENT: begin
                if (handshake_s) begin
                    state_s = COLLECT;
                end else begin
                    state_s = PRESENT;
                end
            end
            default: state_s = COLLECT;
        endcase
    end

    // Sample register and dwell counter; the count also restarts after a transfer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sample_seg_r <= 7'h00;
            sample_dig_r <= {NDIG{1'b0}};
            cnt_r        <= 8'd0;
        end else begin
            sample_seg_r <= seg;
            sample_dig_r <= dig;
            cnt_r        <= handshake_s ? 8'd0 : cnt_s;
        end
    end

    // Frame state, slot registers and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= COLLECT;
            done_r      <= {NDIG{1'b0}};
            err_r       <= {NDIG{1'b0}};
            data_r      <= {(4*NDIG){1'b0}};
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            done_r      <= done_s;
            err_r       <= err_s;
            data_r      <= data_s;
            out_err_r   <= |err_s;
            out_valid_r <= (state_s == PRESENT);
        end
    end

    assign out_data  = data_r;
    assign out_err   = out_err_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_seg_reader.sv
// Self-checking bench for seg_reader: directed vector table, hand-written corner
// sequences and randomized dwells, all compared against a dwell-level reference model.
module tb_seg_reader;

    localparam int S = 4;
    localparam int N = 4;

    logic         clock;
    logic         resetn;
    logic [6:0]   seg;
    logic [N-1:0] dig;
    logic [15:0]  out_data;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;

    int n_checks;
    int n_fail;

    seg_reader #(.STABLE_CYCLES(S), .NDIG(N)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .seg       (seg),
        .dig       (dig),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: a dwell's age in cycles, the frame's slots and presentation flag
    logic [6:0]  m_seg;
    logic [3:0]  m_dig;
    int          m_age;
    bit          m_pres;
    bit   [3:0]  m_done;
    bit   [3:0]  m_errs;
    logic [15:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [6:0] s, output logic [3:0] n, output bit ok);
        n  = 4'h0;
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (glyphs[k] == s) begin
                n  = 4'(k);
                ok = 1'b1;
            end
        end
        if (s == 7'h67) begin
            n  = 4'h9;
            ok = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_seg  = 7'h00;
        m_dig  = 4'h0;
        m_age  = 0;
        m_pres = 1'b0;
        m_done = 4'h0;
        m_errs = 4'h0;
        m_data = 16'h0000;
    endtask

    task automatic model_edge();
        logic [3:0] nib;
        bit         ok;
        bit         was_pres;
        was_pres = m_pres;
        if (seg == m_seg && dig == m_dig && $countones(dig) == 1) m_age++;
        else m_age = 0;
        if (was_pres && out_ready) begin
            m_pres = 1'b0;
            m_done = 4'h0;
            m_errs = 4'h0;
            m_age  = 0;
        end else if (!was_pres && m_age == S) begin
            ref_decode(seg, nib, ok);
            for (int i = 0; i < N; i++) begin
                if (dig[i]) begin
                    m_data[4*i +: 4] = ok ? nib : 4'h0;
                    m_done[i] = 1'b1;
                    m_errs[i] = !ok;
                end
            end
            if (m_done == 4'hF) m_pres = 1'b1;
        end
        m_seg = seg;
        m_dig = dig;
    endtask

    task automatic compare_model();
        chk("valid", 32'(out_valid), 32'(m_pres));
        chk("data",  32'(out_data),  32'(m_data));
        chk("err",   32'(out_err),   32'(|m_errs));
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n, input bit r);
        seg       = s;
        dig       = d;
        out_ready = r;
        for (int c = 0; c < n; c++) cyc();
    endtask

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  dig;
        int          cycles;
        bit          ready;
        bit          exp_valid;
        logic [15:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        seg       = 7'h00;
        dig       = 4'h0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data",  32'(out_data),  32'd0);
        chk("reset_err",   32'(out_err),   32'd0);
        resetn = 1'b1;

        // Directed frames: basic, backpressure, invalid glyph, strobe faults, alt nine
        vecs.push_back('{7'h3F, 4'b0001,  6, 1'b0, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{7'h06, 4'b0010,  6, 1'b0, 1'b0, 16'h0010, 1'b0});
        vecs.push_back('{7'h5B, 4'b0100,  6, 1'b0, 1'b0, 16'h0210, 1'b0});
        vecs.push_back('{7'h4F, 4'b1000,  6, 1'b0, 1'b1, 16'h3210, 1'b0});
        vecs.push_back('{7'h7F, 4'b0001, 10, 1'b0, 1'b1, 16'h3210, 1'b0});
        vecs.push_back('{7'h06, 4'b0001,  1, 1'b1, 1'b0, 16'h3210, 1'b0});
        vecs.push_back('{7'h7F, 4'b0001,  6, 1'b0, 1'b0, 16'h3218, 1'b0});
        vecs.push_back('{7'h7F, 4'b0010,  6, 1'b0, 1'b0, 16'h3288, 1'b0});
        vecs.push_back('{7'h01, 4'b0100,  6, 1'b0, 1'b0, 16'h3088, 1'b1});
        vecs.push_back('{7'h7F, 4'b1000,  6, 1'b0, 1'b1, 16'h8088, 1'b1});
        vecs.push_back('{7'h7F, 4'b1000,  1, 1'b1, 1'b0, 16'h8088, 1'b0});
        vecs.push_back('{7'h3F, 4'b0000, 20, 1'b1, 1'b0, 16'h8088, 1'b0});
        vecs.push_back('{7'h3F, 4'b0011, 20, 1'b1, 1'b0, 16'h8088, 1'b0});
        vecs.push_back('{7'h67, 4'b0001,  6, 1'b0, 1'b0, 16'h8089, 1'b0});
        vecs.push_back('{7'h3F, 4'b0001,  6, 1'b0, 1'b0, 16'h8080, 1'b0});
        vecs.push_back('{7'h6F, 4'b0001,  6, 1'b0, 1'b0, 16'h8089, 1'b0});
        vecs.push_back('{7'h6F, 4'b0010,  6, 1'b0, 1'b0, 16'h8099, 1'b0});
        vecs.push_back('{7'h3F, 4'b0100,  6, 1'b0, 1'b0, 16'h8099, 1'b0});
        vecs.push_back('{7'h3F, 4'b1000,  6, 1'b0, 1'b1, 16'h0099, 1'b0});
        vecs.push_back('{7'h3F, 4'b1000,  1, 1'b1, 1'b0, 16'h0099, 1'b0});

        foreach (vecs[v]) begin
            hold(vecs[v].seg, vecs[v].dig, vecs[v].cycles, vecs[v].ready);
            chk($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_data", v),  32'(out_data),  32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_err", v),   32'(out_err),   32'(vecs[v].exp_err));
        end

        // Stability boundary: 3 counted cycles then a one-cycle glitch, then exactly S
        hold(7'h7F, 4'b0001, 4, 1'b0);
        chk("short_dwell", 32'(out_data[3:0]), 32'h9);
        hold(7'h7F, 4'b0010, 1, 1'b0);
        hold(7'h7F, 4'b0001, S, 1'b0);
        chk("edge_before", 32'(out_data[3:0]), 32'h9);
        cyc();
        chk("edge_capture", 32'(out_data[3:0]), 32'h8);

        // Asynchronous reset with three of four digits captured
        hold(7'h06, 4'b0010, 6, 1'b0);
        hold(7'h5B, 4'b0100, 6, 1'b0);
        chk("pre_reset_data", 32'(out_data), 32'h0218);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_data",  32'(out_data),  32'd0);
        chk("async_err",   32'(out_err),   32'd0);
        #2;
        resetn = 1'b1;
        hold(7'h4F, 4'b1000, 6, 1'b0);
        chk("no_partial_frame", 32'(out_valid), 32'd0);
        hold(7'h3F, 4'b0001, 6, 1'b0);
        hold(7'h06, 4'b0010, 6, 1'b0);
        hold(7'h5B, 4'b0100, 6, 1'b0);
        chk("rescan_valid", 32'(out_valid), 32'd1);
        chk("rescan_data",  32'(out_data),  32'h3210);
        hold(7'h5B, 4'b0100, 1, 1'b1);

        // Randomized dwells: legal glyphs, garbage patterns, bad strobes, random backpressure
        for (int t = 0; t < 400; t++) begin
            logic [6:0] rs;
            logic [3:0] rd;
            int         pick;
            pick = int'($urandom_range(0, 19));
            if (pick < 16)       rs = glyphs[pick];
            else if (pick == 16) rs = 7'h67;
            else                 rs = 7'($urandom);
            if ($urandom_range(0, 9) == 0) rd = 4'($urandom);
            else                           rd = 4'(1 << $urandom_range(0, 3));
            hold(rs, rd, int'($urandom_range(1, 7)), ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
